pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Sequences the multi-cycle, non-overlapped processor pipeline by generating the one-hot pipeline state strobes that enable the instruction frame registers, the decoder, the register file, the ALU and the load/store path. The block also owns the memory request handshake for instruction fetch and data access. It includes a memory-wait watchdog, a retired-instruction counter and halt control. It sits between the core top level and the instruction frame, one instance per core.

## Interface
Parameters:
- DATA_WIDTH, 32, width of retiredCount (matches `DATA_WIDTH).
- MEM_TIMEOUT, 255, maximum number of cycles to wait for memReady before faulting; legal range 1..255.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; while high, the sequencer leaves IDLE and keeps issuing instructions.
- haltRequest  input  1  sampled only in WRITEBACK; requests a stop after the current instruction.
- load_in  input  1  load flag from the instruction frame; sampled in EXECUTE.
- store_in  input  1  store flag from the instruction frame; sampled in EXECUTE.
- memReady  input  1  memory completion strobe; sampled only in FETCH_RECV and MEMREAD.
- fetch_RequestState, fetch_ReceiveState, decodeState, setupState, executeState, memReadState, writebackState  output  1 each  one-hot state strobes; at most one is high per cycle.
- memRequest  output  1  memory access request.
- memWrite  output  1  qualifies memRequest as a store.
- instructionRetired  output  1  single-cycle pulse, high in WRITEBACK.
- retiredCount  output  DATA_WIDTH  count of retired instructions.
- halted  output  1  high in HALT and in FAULT.
- memTimeout  output  1  high in FAULT.

## Operation
- States: IDLE, FETCH_REQ, FETCH_RECV, DECODE, SETUP, EXECUTE, MEMREAD, WRITEBACK, HALT, FAULT. The state is registered; all outputs are decoded from the state register (Moore).
- Reset (asynchronous, reset=0): state goes to IDLE; every output is 0; retiredCount=0; the wait counter is 0.
- Transitions:
  - IDLE goes to FETCH_REQ when run=1; otherwise it stays in IDLE.
  - FETCH_REQ always goes to FETCH_RECV.
  - FETCH_RECV goes to DECODE when memReady=1; otherwise it waits.
  - DECODE goes to SETUP, and SETUP goes to EXECUTE, unconditionally.
  - EXECUTE goes to MEMREAD if load_in or store_in is 1; otherwise it goes to WRITEBACK.
  - MEMREAD goes to WRITEBACK when memReady=1; otherwise it waits.
  - WRITEBACK goes to HALT if haltRequest=1. Otherwise it goes to IDLE if run=0. Otherwise it goes to FETCH_REQ.
  - HALT and FAULT are sticky until reset.
- memRequest=1 in FETCH_REQ, FETCH_RECV and MEMREAD. memWrite=1 only in MEMREAD when the latched access type is store.
- The access type is latched in EXECUTE. If load_in and store_in are both 1, load takes priority and memWrite=0.
- Watchdog:
  - The wait counter clears on entry to FETCH_RECV or MEMREAD.
  - It increments each cycle spent in those states with memReady=0.
  - When it reaches MEM_TIMEOUT while still waiting, the next state is FAULT.
  - If memReady=1 in the same cycle the count would expire, memReady wins and the normal transition is taken.
- retiredCount increments by 1 on each cycle spent in WRITEBACK and wraps from all-ones to 0.
- run dropping mid-instruction does not abort the instruction; run is only examined in IDLE and WRITEBACK.

## Timing
- Non-memory instruction with memReady on the first FETCH_RECV cycle: 6 cycles (FR, FRECV, D, S, E, WB). Back-to-back instructions issue with no bubbles.
- Load or store with zero wait: 7 cycles. Each memReady wait cycle adds 1 cycle.
- memReady asserted during FETCH_REQ, EXECUTE or any other state is ignored and not remembered.
- FAULT entry occurs MEM_TIMEOUT cycles after the first waiting cycle. memTimeout and halted rise in the first FAULT cycle.
- Reset assertion mid-instruction forces IDLE immediately (asynchronously) and drops memRequest. After reset release, the earliest FETCH_REQ is 1 cycle later, provided run=1.

## Test plan
- reset=0 then 1 with run=1 and memReady tied to 1, all-ALU stream → strobes cycle FR, FRECV, D, S, E, WB repeatedly; retiredCount=3 after 18 cycles in the run states.
- Load with memReady delayed 4 cycles in MEMREAD → MEMREAD held 5 cycles with memRequest=1 and memWrite=0; instruction takes 11 cycles; exactly one instructionRetired pulse.
- Store with load_in=store_in=1 → memWrite=0 (load priority). Store alone → memWrite=1 throughout MEMREAD.
- MEM_TIMEOUT=8 with memReady never asserted in FETCH_RECV → FAULT after 8 waiting cycles; memTimeout=halted=1 held through 20 further cycles. Repeat with memReady=1 on the 8th waiting cycle → DECODE is entered, not FAULT.
- haltRequest=1 during WRITEBACK → HALT with halted=1, ignoring run. Separately, run=0 in WRITEBACK → IDLE with all strobes 0; run=1 again → FETCH_REQ on the next cycle.
- Preload retiredCount near wrap (run 2^DATA_WIDTH instructions with DATA_WIDTH=4, i.e. 16 instructions) → count wraps 15 to 0. Assert reset mid-MEMREAD → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Sequencer for a multi-cycle, non-overlapped pipeline: one-hot stage strobes,
// memory request handshake, memory-wait watchdog, retire counter and halt control.
module pipeline_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  haltRequest,
    input  logic                  load_in,
    input  logic                  store_in,
    input  logic                  memReady,
    output logic                  fetch_RequestState,
    output logic                  fetch_ReceiveState,
    output logic                  decodeState,
    output logic                  setupState,
    output logic                  executeState,
    output logic                  memReadState,
    output logic                  writebackState,
    output logic                  memRequest,
    output logic                  memWrite,
    output logic                  instructionRetired,
    output logic [DATA_WIDTH-1:0] retiredCount,
    output logic                  halted,
    output logic                  memTimeout
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH_REQ  = 4'd1;
    localparam logic [3:0] S_FETCH_RECV = 4'd2;
    localparam logic [3:0] S_DECODE     = 4'd3;
    localparam logic [3:0] S_SETUP      = 4'd4;
    localparam logic [3:0] S_EXECUTE    = 4'd5;
    localparam logic [3:0] S_MEMREAD    = 4'd6;
    localparam logic [3:0] S_WRITEBACK  = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;
    localparam logic [3:0] S_FAULT      = 4'd9;

    // Last waiting cycle that may still complete; one more miss faults.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [3:0]            state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  store_q, store_d;
    logic [DATA_WIDTH-1:0] retired_cnt_q, retired_cnt_d;
    logic [10:0]           out_q, out_d;
    logic                  wait_expired_s;

    // Output vector {FR, FRECV, DEC, SETUP, EXE, MEMRD, WB, memRequest, memWrite, halted, memTimeout}.
    function automatic logic [10:0] decode_outputs(input logic [3:0] st, input logic is_store);
        logic [10:0] o;
        o = 11'b000_0000_0000;
        case (st)
            S_FETCH_REQ:  o = 11'b100_0000_1000;
            S_FETCH_RECV: o = 11'b010_0000_1000;
            S_DECODE:     o = 11'b001_0000_0000;
            S_SETUP:      o = 11'b000_1000_0000;
            S_EXECUTE:    o = 11'b000_0100_0000;
            S_MEMREAD: begin
                o    = 11'b000_0010_1000;
                o[2] = is_store;
            end
            S_WRITEBACK:  o = 11'b000_0001_0000;
            S_HALT:       o = 11'b000_0000_0010;
            S_FAULT:      o = 11'b000_0000_0011;
            default:      o = 11'b000_0000_0000;
        endcase
        return o;
    endfunction

    assign wait_expired_s = (wait_cnt_q == WAIT_LAST);

    // Next-state, watchdog, access-type latch and retire-count logic.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        store_d       = store_q;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_REQ;
                else     state_d = S_IDLE;
            end
            S_FETCH_REQ: begin
                state_d    = S_FETCH_RECV;
                wait_cnt_d = 8'd0;
            end
            S_FETCH_RECV: begin
                if (memReady)            state_d = S_DECODE;
                else if (wait_expired_s) state_d = S_FAULT;
                else                     wait_cnt_d = wait_cnt_q + 8'd1;
            end
            S_DECODE: state_d = S_SETUP;
            S_SETUP:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                // Load wins when both flags are set.
                store_d = store_in & ~load_in;
                if (load_in | store_in) begin
                    state_d    = S_MEMREAD;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMREAD: begin
                if (memReady)            state_d = S_WRITEBACK;
                else if (wait_expired_s) state_d = S_FAULT;
                else                     wait_cnt_d = wait_cnt_q + 8'd1;
            end
            S_WRITEBACK: begin
                retired_cnt_d = retired_cnt_q + DATA_WIDTH'(1);
                if (haltRequest) state_d = S_HALT;
                else if (!run)   state_d = S_IDLE;
                else             state_d = S_FETCH_REQ;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        out_d = decode_outputs(state_d, store_d);
    end

    // State, counters and registered output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            store_q       <= 1'b0;
            retired_cnt_q <= '0;
            out_q         <= 11'b000_0000_0000;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            store_q       <= store_d;
            retired_cnt_q <= retired_cnt_d;
            out_q         <= out_d;
        end
    end

    assign fetch_RequestState = out_q[10];
    assign fetch_ReceiveState = out_q[9];
    assign decodeState        = out_q[8];
    assign setupState         = out_q[7];
    assign executeState       = out_q[6];
    assign memReadState       = out_q[5];
    assign writebackState     = out_q[4];
    assign memRequest         = out_q[3];
    assign memWrite           = out_q[2];
    assign instructionRetired = out_q[4];
    assign halted             = out_q[1];
    assign memTimeout         = out_q[0];
    assign retiredCount       = retired_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a driver issues randomized instructions and
// pushes per-instruction expectations; a negedge monitor pops them on each retirement.
module tb_pipeline_sequencer;

    localparam int DW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset, run, haltRequest, load_in, store_in, memReady;
    logic          fetch_RequestState, fetch_ReceiveState, decodeState, setupState;
    logic          executeState, memReadState, writebackState;
    logic          memRequest, memWrite, instructionRetired, halted, memTimeout;
    logic [DW-1:0] retiredCount;
    logic [6:0]    strobes;
    logic [15:0]   all_outs;

    int errors = 0;
    int checks = 0;
    int model_retired = 0;

    typedef struct {
        int len;
        int memcyc;
        int wrcyc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    pipeline_sequencer #(.DATA_WIDTH(DW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .haltRequest(haltRequest),
        .load_in(load_in), .store_in(store_in), .memReady(memReady),
        .fetch_RequestState(fetch_RequestState), .fetch_ReceiveState(fetch_ReceiveState),
        .decodeState(decodeState), .setupState(setupState), .executeState(executeState),
        .memReadState(memReadState), .writebackState(writebackState),
        .memRequest(memRequest), .memWrite(memWrite), .instructionRetired(instructionRetired),
        .retiredCount(retiredCount), .halted(halted), .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    assign strobes  = {fetch_RequestState, fetch_ReceiveState, decodeState, setupState,
                       executeState, memReadState, writebackState};
    assign all_outs = {strobes, memRequest, memWrite, instructionRetired, halted, memTimeout,
                       retiredCount};

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic noise();
        memReady    = 1'($urandom);
        load_in     = 1'($urandom);
        store_in    = 1'($urandom);
        haltRequest = 1'($urandom);
        run         = 1'($urandom);
    endtask

    // Monitor: per-cycle sanity plus per-instruction scoreboard comparison at writeback.
    int mon_len = 0, mon_mem = 0, mon_wr = 0;
    always @(negedge clk) begin
        if (!reset) begin
            mon_len = 0; mon_mem = 0; mon_wr = 0;
        end else begin
            check("one_hot", ($countones(strobes) <= 1) ? 1 : 0, 1);
            check("memRequest", memRequest,
                  (fetch_RequestState || fetch_ReceiveState || memReadState) ? 1 : 0);
            if (fetch_RequestState) begin
                mon_len = 1; mon_mem = 0; mon_wr = 0;
            end else begin
                mon_len++;
            end
            if (memReadState) begin
                mon_mem++;
                if (memWrite) mon_wr++;
            end else begin
                check("memWrite_outside_memread", memWrite, 0);
            end
            check("retire_pulse", instructionRetired, writebackState);
            if (writebackState) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr_cycles", mon_len, e.len);
                    check("memread_cycles", mon_mem, e.memcyc);
                    check("memwrite_cycles", mon_wr, e.wrcyc);
                    check("retired_count", retiredCount, e.cnt);
                end
            end
        end
    end

    // Issue one instruction: fw/mw are memReady wait cycles in fetch and memory phases.
    task automatic do_instr(input int fw, input int mw, input bit ld, input bit st,
                            input bit hreq, input bit run_wb);
        exp_t e;
        int   guard, fc, mc;
        bit   mem;
        mem      = ld | st;
        e.memcyc = mem ? mw + 1 : 0;
        e.len    = 6 + fw + e.memcyc;
        e.wrcyc  = (st && !ld) ? e.memcyc : 0;
        e.cnt    = model_retired;
        model_retired = (model_retired + 1) % (1 << DW);
        exp_q.push_back(e);
        fc = 0; mc = 0; guard = 0;
        while (!fetch_RequestState && guard < 8) begin
            noise();
            if (strobes == 7'd0 && !halted) run = 1'b1;
            step();
            guard++;
        end
        check("reach_fetch_req", fetch_RequestState, 1);
        guard = 0;
        while (!writebackState && guard < 64) begin
            noise();
            if (fetch_ReceiveState) begin
                memReady = (fc == fw); fc++;
            end else if (memReadState) begin
                memReady = (mc == mw); mc++;
            end else if (executeState) begin
                load_in = ld; store_in = st;
            end
            step();
            guard++;
        end
        check("reach_writeback", writebackState, 1);
        noise();
        haltRequest = hreq;
        run         = run_wb;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_retired = 0;
        exp_q.delete();
        step();
        run = 1'b1; memReady = 1'b0; haltRequest = 1'b0; load_in = 1'b0; store_in = 1'b0;
        reset = 1'b1;
        step();
        check("fetch_after_reset", fetch_RequestState, 1);
    endtask

    initial begin
        int wc, guard;
        reset = 1'b0; run = 1'b0; haltRequest = 1'b0;
        load_in = 1'b0; store_in = 1'b0; memReady = 1'b0;
        repeat (2) step();
        check("reset_outputs", all_outs, 0);
        reset = 1'b1;
        run   = 1'b1;
        step();
        check("fetch_after_reset", fetch_RequestState, 1);

        repeat (3) do_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("count_after_3_alu", retiredCount, 3);
        do_instr(0, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        do_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_instr(2, 3, 1'b0, 1'b1, 1'b0, 1'b1);
        do_instr(7, 7, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            do_instr($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                     1'b0, 1'b1);
        do_instr(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // run low at writeback: idle with no strobes until run returns
        memReady = 1'b1; haltRequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_strobes", {strobes, memRequest, halted}, 0);
            step();
        end
        run = 1'b1;
        step();
        check("restart_fetch", fetch_RequestState, 1);

        do_instr(1, 1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("halt_state", {strobes, halted, memTimeout}, 2);
            noise();
            step();
        end
        check("scoreboard_drained", exp_q.size(), 0);

        // watchdog expiry in fetch receive
        do_reset();
        memReady = 1'b0;
        step();
        wc = 0; guard = 0;
        while (fetch_ReceiveState && guard < 20) begin
            wc++; step(); guard++;
        end
        check("fault_wait_cycles", wc, TMO);
        for (int i = 0; i < 20; i++) begin
            check("fault_state", {strobes, memRequest, halted, memTimeout}, 3);
            noise();
            step();
        end

        // asynchronous reset while a store waits in memread
        do_reset();
        guard = 0;
        while (!memReadState && guard < 20) begin
            memReady = fetch_ReceiveState; load_in = 1'b0; store_in = 1'b1;
            step(); guard++;
        end
        memReady = 1'b0;
        step();
        check("memread_store_active", {memReadState, memRequest, memWrite}, 7);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", all_outs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
